// File: rtl/core_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_responder_pkg
//  Description : Shared definitions for the core memory responder: default
//                geometry, FSM state encoding and the round-robin pointer
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_mem_responder_pkg;

  localparam int DEF_NO_OF_CORES = 5;
  localparam int DEF_DATA_LEN    = 16;
  localparam int DEF_ADDRESS_LEN = 12;
  localparam int DEF_MEM_DEPTH   = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Pointer needs $clog2(n) bits; keep at least one bit for a single core.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_responder_rr_arbiter
//  Description : Purely combinational round-robin grant. Picks the first set
//                bit of eligible_i at or after ptr_i, wrapping at N (not at a
//                power of two). The pointer register lives in the parent.
//  Ports       : eligible_i - request vector after masking
//                ptr_i      - search start index (0..N-1)
//                grant_o    - one-hot grant
//                idx_o      - index of granted bit
//                valid_o    - a grant was made
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_responder_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] w_rot;
  logic [PW:0]  w_pos;

  always_comb begin
    // Rotate so that bit 0 corresponds to the pointer position.
    w_rot   = N'({eligible_i, eligible_i} >> ptr_i);
    w_pos   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Descending scan: the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos = {1'b0, ptr_i} + (PW+1)'(k);
        if (w_pos >= (PW+1)'(N)) begin
          w_pos = w_pos - (PW+1)'(N);
        end
        idx_o   = w_pos[PW-1:0];
        valid_o = 1'b1;
      end
    end
    grant_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_responder
//  Description : Memory responder shared by NO_OF_CORES initiators. Holds a
//                single-port data memory, arbitrates round-robin and runs one
//                access at a time through IDLE -> ACCESS -> RESP.
//                Optional macro CORE_MEM_BROADCAST_READ_EN: same-address
//                reads from several eligible cores are served together.
//  Ports       : clk_i       - clock
//                rst_ni      - asynchronous active-low reset
//                req_valid_i - per-core request (held until rsp_valid_o)
//                req_write_i - per-core 1 = write, 0 = read
//                req_addr_i  - per-core address slices
//                req_wdata_i - per-core write-data slices
//                rsp_valid_o - per-core one-cycle completion pulse
//                rsp_rdata_o - per-core read data, held until next read
//                busy_o      - FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int NO_OF_CORES = DEF_NO_OF_CORES,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NO_OF_CORES-1:0]          req_valid_i,
  input  logic [NO_OF_CORES-1:0]          req_write_i,
  input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] req_addr_i,
  input  logic [DATA_LEN*NO_OF_CORES-1:0] req_wdata_i,
  output logic [NO_OF_CORES-1:0]          rsp_valid_o,
  output logic [DATA_LEN*NO_OF_CORES-1:0] rsp_rdata_o,
  output logic                            busy_o
);

  localparam int PW = ptr_width(NO_OF_CORES);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_LEN:0] DEPTH_LIMIT = (ADDRESS_LEN+1)'(MEM_DEPTH);
  localparam logic [PW-1:0]        LAST_CORE   = PW'(NO_OF_CORES - 1);

  state_e                         state_q, state_d;
  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [NO_OF_CORES-1:0]         mask_q;
  logic [NO_OF_CORES-1:0]         served_q;
  logic [PW-1:0]                  last_q;
  logic                           wr_q;
  logic [ADDRESS_LEN-1:0]         addr_q;
  logic [DATA_LEN-1:0]            wdata_q;
  logic [DATA_LEN-1:0]            rdata_q;
  logic [DATA_LEN*NO_OF_CORES-1:0] rsp_rdata_q;
  logic [DATA_LEN-1:0]            mem_q [MEM_DEPTH];

  logic [ADDRESS_LEN-1:0]         w_addr  [NO_OF_CORES];
  logic [DATA_LEN-1:0]            w_wdata [NO_OF_CORES];
  logic [NO_OF_CORES-1:0]         w_eligible;
  logic [NO_OF_CORES-1:0]         w_grant;
  logic [PW-1:0]                  w_gidx;
  logic                           w_gvalid;
  logic [NO_OF_CORES-1:0]         w_served;
  logic [PW-1:0]                  w_last;
  logic                           w_in_range;
  logic [AW-1:0]                  w_mem_idx;
  logic [DATA_LEN*NO_OF_CORES-1:0] w_rsp_rdata;

  for (genvar c = 0; c < NO_OF_CORES; c++) begin : g_unpack
    assign w_addr[c]  = req_addr_i[c*ADDRESS_LEN +: ADDRESS_LEN];
    assign w_wdata[c] = req_wdata_i[c*DATA_LEN +: DATA_LEN];
  end

  // The core just served is hidden for one IDLE cycle so a request still
  // held after its response is not taken a second time.
  assign w_eligible = req_valid_i & ~mask_q;

  core_mem_responder_rr_arbiter #(
    .N  (NO_OF_CORES),
    .PW (PW)
  ) u_arb (
    .eligible_i (w_eligible),
    .ptr_i      (ptr_q),
    .grant_o    (w_grant),
    .idx_o      (w_gidx),
    .valid_o    (w_gvalid)
  );

`ifdef CORE_MEM_BROADCAST_READ_EN
  logic [NO_OF_CORES-1:0] w_srot;
  logic [PW:0]            w_spos;

  always_comb begin
    w_served = w_grant;
    if (w_gvalid && !req_write_i[w_gidx]) begin
      for (int c = 0; c < NO_OF_CORES; c++) begin
        if (w_eligible[c] && !req_write_i[c] && (w_addr[c] == w_addr[w_gidx])) begin
          w_served[c] = 1'b1;
        end
      end
    end
    // Furthest served core in wrapped order from the pointer.
    w_srot = NO_OF_CORES'({w_served, w_served} >> ptr_q);
    w_spos = '0;
    w_last = w_gidx;
    for (int k = 0; k < NO_OF_CORES; k++) begin
      if (w_srot[k]) begin
        w_spos = {1'b0, ptr_q} + (PW+1)'(k);
        if (w_spos >= (PW+1)'(NO_OF_CORES)) begin
          w_spos = w_spos - (PW+1)'(NO_OF_CORES);
        end
        w_last = w_spos[PW-1:0];
      end
    end
  end
`else
  assign w_served = w_grant;
  assign w_last   = w_gidx;
`endif

  // Out-of-range addresses never touch the array (no aliasing).
  assign w_in_range = ({1'b0, addr_q} < DEPTH_LIMIT);
  assign w_mem_idx  = addr_q[AW-1:0];
  assign ptr_d      = (last_q == LAST_CORE) ? '0 : last_q + PW'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_gvalid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP) ? served_q : '0;
    // Read data is visible in the RESP cycle itself, then held.
    w_rsp_rdata = rsp_rdata_q;
    for (int c = 0; c < NO_OF_CORES; c++) begin
      if ((state_q == ST_RESP) && !wr_q && served_q[c]) begin
        w_rsp_rdata[c*DATA_LEN +: DATA_LEN] = rdata_q;
      end
    end
  end

  assign rsp_rdata_o = w_rsp_rdata;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      mask_q      <= '0;
      served_q    <= '0;
      last_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mask_q <= '0;
          if (w_gvalid) begin
            served_q <= w_served;
            last_q   <= w_last;
            wr_q     <= req_write_i[w_gidx];
            addr_q   <= w_addr[w_gidx];
            wdata_q  <= w_wdata[w_gidx];
          end
        end
        ST_ACCESS: begin
          if (!wr_q) begin
            rdata_q <= w_in_range ? mem_q[w_mem_idx] : '0;
          end
        end
        ST_RESP: begin
          ptr_q       <= ptr_d;
          mask_q      <= served_q;
          rsp_rdata_q <= w_rsp_rdata;
        end
        default: ;
      endcase
    end
  end

  // Memory is not reset; an async reset drops the FSM out of ACCESS before
  // the edge, so an interrupted write is never committed.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_ACCESS) && wr_q && w_in_range) begin
      mem_q[w_mem_idx] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_responder
//  Description : Self-checking bench for core_mem_responder with a
//                cycle-level transaction model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_responder;

  localparam int N  = 5;
  localparam int DL = 16;
  localparam int AL = 12;
  localparam int MD = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_write = '0;
  logic [AL*N-1:0]   req_addr  = '0;
  logic [DL*N-1:0]   req_wdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [DL*N-1:0]   rsp_rdata;
  logic              busy;

  core_mem_responder #(
    .NO_OF_CORES (N),
    .DATA_LEN    (DL),
    .ADDRESS_LEN (AL),
    .MEM_DEPTH   (MD)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  logic [DL-1:0]   mdl_mem [MD];
  logic [DL*N-1:0] exp_rdata = '0;
  logic [N-1:0]    exp_valid = '0;
  logic            exp_busy  = 1'b0;
  int              cyc = 0;
  int              rr = 0;
  int              free_cyc = 0;
  logic [N-1:0]    last_mask = '0;
  int              mask_cyc = -10;
  bit              pend = 0;
  int              pend_cyc, pend_addr, pend_last;
  bit              pend_wr;
  logic [DL-1:0]   pend_data;
  logic [N-1:0]    pend_mask;

  bit              done_seen [N];
  int              hold [N];
  int              pulse_cnt [N];
  int              last_rsp_cyc [N];
  int              rsp_log[$];
  int              rsp_log_cyc[$];

  int              m_g, m_c;
  logic [N-1:0]    m_elig;
  logic [DL-1:0]   m_d;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      pend = 0; rr = 0; last_mask = '0; mask_cyc = -10;
      free_cyc = cyc; exp_rdata = '0; exp_valid = '0; exp_busy = 1'b0;
    end else begin
      // Requests present in cycle cyc-1 were sampled at this edge.
      if (!pend && (cyc - 1) >= free_cyc) begin
        m_elig = req_valid & ~(((cyc - 1) == mask_cyc) ? last_mask : '0);
        m_g = -1;
        for (int k = 0; k < N; k++) begin
          m_c = (rr + k) % N;
          if (m_g < 0 && m_elig[m_c]) m_g = m_c;
        end
        if (m_g >= 0) begin
          pend      = 1;
          pend_cyc  = cyc + 1;
          pend_wr   = req_write[m_g];
          pend_addr = int'(req_addr[m_g*AL +: AL]);
          pend_data = req_wdata[m_g*DL +: DL];
          pend_mask = '0;
          pend_mask[m_g] = 1'b1;
          pend_last = m_g;
`ifdef CORE_MEM_BROADCAST_READ_EN
          if (!pend_wr) begin
            for (int k = 0; k < N; k++) begin
              m_c = (rr + k) % N;
              if (m_elig[m_c] && !req_write[m_c] && int'(req_addr[m_c*AL +: AL]) == pend_addr) begin
                pend_mask[m_c] = 1'b1;
                pend_last = m_c;
              end
            end
          end
`endif
        end
      end
      exp_busy  = pend;
      exp_valid = '0;
      if (pend && pend_cyc == cyc) begin
        if (pend_wr) begin
          if (pend_addr < MD) mdl_mem[pend_addr] = pend_data;
        end else begin
          m_d = (pend_addr < MD) ? mdl_mem[pend_addr] : '0;
          for (int c = 0; c < N; c++) if (pend_mask[c]) exp_rdata[c*DL +: DL] = m_d;
        end
        exp_valid = pend_mask;
        last_mask = pend_mask;
        mask_cyc  = cyc + 1;
        rr        = (pend_last + 1) % N;
        free_cyc  = cyc + 1;
        pend      = 0;
      end
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_valid));
    chk("busy", 128'(busy), 128'(exp_busy));
    chk("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
    for (int c = 0; c < N; c++) begin
      if (rsp_valid[c]) begin
        done_seen[c] = 1;
        pulse_cnt[c]++;
        last_rsp_cyc[c] = cyc;
        rsp_log.push_back(c);
        rsp_log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int t_req;

  task automatic set_req(input int c, input bit wr, input int addr, input int data);
    req_valid[c] = 1'b1;
    req_write[c] = wr;
    req_addr[c*AL +: AL]  = addr[AL-1:0];
    req_wdata[c*DL +: DL] = data[DL-1:0];
    done_seen[c] = 0;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (done_seen[c]) begin
          if (hold[c] > 0) hold[c]--;
          else begin req_valid[c] = 1'b0; done_seen[c] = 0; end
        end
      end
      n++;
    end while ((req_valid != '0 || busy) && n < max);
    if (n >= max) begin
      n_total++;
      $display("FAIL timeout: still busy after %0d cycles, req_valid=%0h", max, req_valid);
      req_valid = '0;
    end
  endtask

  task automatic xact(input int c, input bit wr, input int addr, input int data);
    @(negedge clk);
    set_req(c, wr, addr, data);
    t_req = cyc;
    run_idle(60);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DL-1:0] rd(input int c);
    return rsp_rdata[c*DL +: DL];
  endfunction

  int exp_core [4] = '{0, 1, 3, 4};
  int exp_off  [4] = '{2, 5, 8, 11};
  int p0, t0;

  initial begin
    for (int c = 0; c < N; c++) begin
      done_seen[c] = 0; hold[c] = 0; pulse_cnt[c] = 0; last_rsp_cyc[c] = -1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_rdata", 128'(rsp_rdata), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);

    // Single write then read by core 2.
    xact(2, 1'b1, 'h005, 'h1234);
    chk("lat_write", 128'(last_rsp_cyc[2] - t_req), 128'd2);
    xact(2, 1'b0, 'h005, 0);
    chk("lat_read", 128'(last_rsp_cyc[2] - t_req), 128'd2);
    chk("read_data_c2", 128'(rd(2)), 128'h1234);

    // Preload.
    xact(0, 1'b1, 'h030, 'hC000);
    xact(0, 1'b1, 'h031, 'hC001);
    xact(0, 1'b1, 'h033, 'hC003);
    xact(0, 1'b1, 'h034, 'hC004);
    xact(1, 1'b1, 'h010, 'h0A0A);
    xact(3, 1'b1, 20, 'h2020);
    xact(4, 1'b1, 'h023, 'h5A5A);

    // Contention from pointer 0.
    do_reset();
    rsp_log.delete();
    rsp_log_cyc.delete();
    @(negedge clk);
    set_req(0, 1'b0, 'h030, 0);
    set_req(1, 1'b0, 'h031, 0);
    set_req(3, 1'b0, 'h033, 0);
    set_req(4, 1'b0, 'h034, 0);
    t0 = cyc;
    run_idle(80);
    chk("cont_count", 128'(rsp_log.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_log.size()) begin
        chk("cont_order", 128'(rsp_log[i]), 128'(exp_core[i]));
        chk("cont_time", 128'(rsp_log_cyc[i] - t0), 128'(exp_off[i]));
      end
    end
    chk("cont_d0", 128'(rd(0)), 128'hC000);
    chk("cont_d1", 128'(rd(1)), 128'hC001);
    chk("cont_d3", 128'(rd(3)), 128'hC003);
    chk("cont_d4", 128'(rd(4)), 128'hC004);

    // Core 1 holds its request one extra cycle after the response.
    p0 = pulse_cnt[1];
    hold[1] = 1;
    xact(1, 1'b1, 'h040, 'h1111);
    repeat (4) @(negedge clk);
    chk("no_double_pulse", 128'(pulse_cnt[1] - p0), 128'd1);
    xact(1, 1'b0, 'h040, 0);
    chk("no_double_data", 128'(rd(1)), 128'h1111);

    // Out-of-range address.
    xact(3, 1'b1, 120, 'hDEAD);
    xact(3, 1'b0, 120, 0);
    chk("oor_read", 128'(rd(3)), 128'h0);
    xact(3, 1'b0, 20, 0);
    chk("no_alias", 128'(rd(3)), 128'h2020);

    // Reset during the ACCESS cycle of a write.
    p0 = pulse_cnt[0];
    @(negedge clk);
    set_req(0, 1'b1, 'h010, 'hBEEF);
    @(negedge clk);
    chk("busy_in_access", 128'(busy), 128'd1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("busy_after_reset", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("no_rsp_on_reset", 128'(pulse_cnt[0] - p0), 128'd0);
    xact(0, 1'b0, 'h010, 0);
    chk("reset_write_dropped", 128'(rd(0)), 128'h0A0A);

    // All five cores read the same address together.
    rsp_log.delete();
    rsp_log_cyc.delete();
    @(negedge clk);
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 'h023, 0);
    t0 = cyc;
    run_idle(80);
    chk("bcast_count", 128'(rsp_log.size()), 128'd5);
`ifdef CORE_MEM_BROADCAST_READ_EN
    for (int i = 0; i < rsp_log_cyc.size(); i++)
      chk("bcast_time", 128'(rsp_log_cyc[i] - t0), 128'd2);
`endif
    for (int c = 0; c < N; c++) chk("bcast_data", 128'(rd(c)), 128'h5A5A);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Responder side of the per-core memory request interface. Serves NO_OF_CORES initiator cores that share one memory.
- Holds the shared data memory internally (single port). Arbitrates concurrent core requests round-robin and performs one access at a time.
- Returns read data and a per-core one-cycle response pulse.
- Sits between the core array and the data memory, in place of a direct per-core wired RAM connection.

Parameters:
- NO_OF_CORES, 5, number of requesting cores.
- DATA_LEN, 16, data word width.
- ADDRESS_LEN, 12, per-core address width.
- MEM_DEPTH, 4096, number of words stored; must be ≤ 2**ADDRESS_LEN.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NO_OF_CORES  per-core request, held high until that core's rsp_valid.
- req_write  input  NO_OF_CORES  per-core: 1 = write, 0 = read.
- req_addr  input  ADDRESS_LEN*NO_OF_CORES  core c uses slice [c*ADDRESS_LEN +: ADDRESS_LEN].
- req_wdata  input  DATA_LEN*NO_OF_CORES  core c uses slice [c*DATA_LEN +: DATA_LEN].
- rsp_valid  output  NO_OF_CORES  one-cycle completion pulse per core.
- rsp_rdata  output  DATA_LEN*NO_OF_CORES  per-core read data, held until that core's next read completes.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (reset low, async):
  - rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - FSM forced to IDLE; round-robin pointer = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Form eligible = req_valid & ~mask, where mask holds the core served in the previous RESP for this one cycle only.
  - If eligible ≠ 0: grant the first set bit at or after the pointer (wrapping).
  - Latch the granted core's index, write flag, address and wdata; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Write: mem[addr] <= wdata.
  - Read: capture mem[addr] into an internal read register.
  - Go to RESP.
- RESP:
  - rsp_valid[g] = 1 for exactly this cycle.
  - On a read, rsp_rdata slice g updates with the captured word in the same cycle.
  - Pointer <= (g+1) mod NO_OF_CORES; go to IDLE with mask = bit g.
- Latency: the request is sampled in IDLE at cycle T; rsp_valid is high in cycle T+2. Sustained throughput is one transaction per 3 cycles.
- Initiator rule: deassert req_valid in the cycle after rsp_valid, or change to a new request. The mask cycle guarantees the old request is never served twice.
- req_valid dropping while the request is in ACCESS/RESP: the transaction still completes and rsp_valid still pulses.
- Address ≥ MEM_DEPTH: a write is discarded, a read returns 0, and the response is issued normally.
- All cores requesting together: served in pointer order, each core exactly once per NO_OF_CORES grants (fairness bound).
- Reset asserted mid-transaction: the access is aborted. A write in ACCESS during the reset edge is not committed. No rsp_valid is issued.
- Width rules: the pointer is $clog2(NO_OF_CORES) bits and wraps at NO_OF_CORES, not at a power of two.

Optional Feature:
- Macro: CORE_MEM_BROADCAST_READ_EN.
- With it, when the grant is a read, every other eligible core that is also reading the same address is captured in the same IDLE cycle. All of them receive rsp_valid and the same rsp_rdata word in one RESP. The mask covers all served cores. The pointer advances past the highest-index core served in wrapped order.
- This targets cores executing in lockstep.
- Without it, every core is served individually.

Decomposition:
- Shared package: DATA_LEN/ADDRESS_LEN/NO_OF_CORES defaults, the FSM state enum (IDLE, ACCESS, RESP), and a pointer-width function.
- One sub-module: rr_arbiter.
  - Combinational grant: inputs are eligible vector and pointer; outputs are one-hot grant and index.
  - Holds no state; the pointer register lives in the parent.

Test Plan:
- Single write, then read: core 2 writes addr 0x005 data 0x1234, then reads 0x005. Required: rsp_valid[2] pulses 2 cycles after each request; rsp_rdata slice 2 = 0x1234.
- Contention: pointer 0; cores 0,1,3,4 all read distinct preloaded addresses in the same cycle. Required: responses in order 0,1,3,4 at cycles T+2, T+5, T+8, T+11, each with its own data.
- No double service: core 1 holds req_valid for one extra cycle after rsp_valid. Required: exactly one rsp_valid[1] pulse and one memory write.
- Out of range: with MEM_DEPTH=100, a write to addr 120 followed by a read of 120 returns 0, and mem[20] is unchanged (no aliasing).
- Reset mid-op: reset goes low in ACCESS of a write of 0xBEEF to 0x010. Required: rsp_valid stays 0, busy goes 0, and a later read of 0x010 returns its old value.
- (CORE_MEM_BROADCAST_READ_EN) Cores 0–4 all read 0x023 together. Required: all five rsp_valid bits pulse in the same cycle T+2 with identical data.
